// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave exposing a snapshot register of a fabric value to the processor.
// Captures user_data_in while armed; the processor reads DATA, CTRL and STATUS.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h01100600,
    parameter logic [31:0] C_HIGHADDR   = 32'h011006FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    input  logic [31:0] user_data_in,
    input  logic        user_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [5:0] IDX_DATA   = 6'd0;
    localparam logic [5:0] IDX_CTRL   = 6'd1;
    localparam logic [5:0] IDX_STATUS = 6'd2;

    state_t      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic [15:0] count_q, count_d;
    logic        valid_q, valid_d;
    logic        armed_q, armed_d;
    logic        cont_q, cont_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic        wr_arm_q, wr_arm_d;
    logic        wr_cont_q, wr_cont_d;
    logic        rdclr_q, rdclr_d;

    logic [31:0] addr;
    logic [31:0] off;
    logic [5:0]  idx;
    logic        in_range;
    logic        hit;
    logic        ack_edge;
    logic        capture;
    logic [31:0] reg_rd;

    assign addr     = OPB_ABus;
    assign off      = addr - C_BASEADDR;
    assign idx      = off[7:2];
    assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign hit      = OPB_select && in_range && (state_q == IDLE);
    assign ack_edge = (state_q == ACK);
    assign capture  = armed_q && user_valid;

    always_comb begin
        reg_rd = 32'h0;
        unique case (idx)
            IDX_DATA:   reg_rd = shadow_q;
            IDX_CTRL:   reg_rd = {30'h0, cont_q, armed_q};
            IDX_STATUS: reg_rd = {count_q, 13'h0, cont_q, valid_q, armed_q};
            default:    reg_rd = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = hit ? ACK : IDLE;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction attributes are latched at the hit edge and applied at the ACK edge.
    always_comb begin
        rdata_d   = rdata_q;
        wr_d      = wr_q;
        wr_arm_d  = wr_arm_q;
        wr_cont_d = wr_cont_q;
        rdclr_d   = rdclr_q;
        if (hit) begin
            rdata_d   = reg_rd;
            wr_d      = !OPB_RNW && OPB_BE[3] && (idx == IDX_CTRL);
            wr_arm_d  = OPB_DBus[31];
            wr_cont_d = OPB_DBus[30];
            rdclr_d   = OPB_RNW && (idx == IDX_DATA);
        end else if (ack_edge) begin
            wr_d    = 1'b0;
            rdclr_d = 1'b0;
        end
    end

    // Capture beats a same-edge DATA read clear; a CTRL write beats capture's disarm.
    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        valid_d  = valid_q;
        armed_d  = armed_q;
        cont_d   = cont_q;
        if (ack_edge && rdclr_q) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            shadow_d = user_data_in;
            count_d  = count_q + 16'd1;
            valid_d  = 1'b1;
            if (!cont_q) begin
                armed_d = 1'b0;
            end
        end
        if (ack_edge && wr_q) begin
            armed_d = wr_arm_q;
            cont_d  = wr_cont_q;
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q   <= IDLE;
            shadow_q  <= 32'h0;
            count_q   <= 16'h0;
            valid_q   <= 1'b0;
            armed_q   <= 1'b0;
            cont_q    <= 1'b0;
            rdata_q   <= 32'h0;
            wr_q      <= 1'b0;
            wr_arm_q  <= 1'b0;
            wr_cont_q <= 1'b0;
            rdclr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            armed_q   <= armed_d;
            cont_q    <= cont_d;
            rdata_q   <= rdata_d;
            wr_q      <= wr_d;
            wr_arm_q  <= wr_arm_d;
            wr_cont_q <= wr_cont_d;
            rdclr_q   <= rdclr_d;
        end
    end

    assign Sl_xferAck = ack_edge;
    assign Sl_DBus    = ack_edge ? rdata_q : 32'h0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29],
                         off[31:8], off[1:0], C_OPB_AWIDTH[0],
                         C_OPB_DWIDTH[0], C_FAMILY.len()};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Bench for opb_register_simulink2ppc_snap: directed and random OPB accesses
// and captures compared against a register-level behavioural model.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h01100600;
    localparam logic [31:0] HIGH = 32'h011006FF;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_valid;

    int ncmp = 0;
    int nerr = 0;

    logic [31:0] m_shadow;
    int          m_count;
    bit          m_valid, m_armed, m_cont;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus),
        .OPB_BE(OPB_BE), .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW),
        .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
        .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck),
        .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
        .user_data_in(user_data_in), .user_valid(user_valid)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = 0; m_count = 0; m_valid = 0; m_armed = 0; m_cont = 0;
    endtask

    function automatic logic [31:0] model_reg(input int idx);
        case (idx)
            0: return m_shadow;
            1: return 32'(m_cont) * 2 + 32'(m_armed);
            2: return 32'(m_count) * 65536 + 32'(m_cont) * 4
                      + 32'(m_valid) * 2 + 32'(m_armed);
            default: return 0;
        endcase
    endfunction

    task automatic model_capture(input logic [31:0] d);
        if (m_armed) begin
            m_shadow = d;
            m_valid  = 1;
            m_count  = (m_count + 1) % 65536;
            if (!m_cont) m_armed = 0;
        end
    endtask

    // One OPB transfer; optionally a user_valid pulse lands on the ACK edge.
    task automatic access(input string tag, input logic [31:0] addr,
                          input bit rnw, input logic [3:0] be,
                          input logic [31:0] wd, input bit cap,
                          input logic [31:0] cd);
        bit          hit;
        int          idx;
        logic [31:0] exp_rd;
        logic        a_pre, a_hit, a_post;
        logic [31:0] rd;
        bit          pre_armed, pre_cont;
        hit    = (addr >= BASE) && (addr <= HIGH);
        idx    = int'((addr - BASE) / 4);
        exp_rd = hit ? model_reg(idx) : 0;
        @(negedge OPB_Clk);
        OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be;
        OPB_DBus = rnw ? 32'h0 : wd; OPB_select = 1;
        #1 a_pre = Sl_xferAck;
        @(posedge OPB_Clk);
        #1 a_hit = Sl_xferAck; rd = Sl_DBus;
        OPB_select = 0; OPB_DBus = 0;
        if (cap) begin
            user_valid = 1; user_data_in = cd;
        end
        @(posedge OPB_Clk);
        #1 a_post = Sl_xferAck;
        user_valid = 0;
        chk({tag, "_ack_pre"}, 32'(a_pre), 0);
        chk({tag, "_ack"}, 32'(a_hit), 32'(hit));
        chk({tag, "_ack_post"}, 32'(a_post), 0);
        if (hit && rnw) chk({tag, "_rd"}, rd, exp_rd);
        pre_armed = m_armed; pre_cont = m_cont;
        if (hit && rnw && idx == 0) m_valid = 0;
        if (cap) model_capture(cd);
        if (hit && !rnw && be[0] && idx == 1) begin
            m_armed = wd[0]; m_cont = wd[1];
        end
        if (!(hit && !rnw && be[0] && idx == 1) && cap && pre_armed && !pre_cont)
            m_armed = 0;
    endtask

    task automatic rd_reg(input string tag, input int idx);
        access(tag, BASE + 32'(idx) * 4, 1, 4'hF, 0, 0, 0);
    endtask

    task automatic wr_ctrl(input string tag, input logic [31:0] v,
                           input logic [3:0] be);
        access(tag, BASE + 4, 0, be, v, 0, 0);
    endtask

    task automatic capture_run(input int n, input logic [31:0] d0, input bit rnd);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? $urandom : d0;
            @(negedge OPB_Clk);
            user_valid = 1; user_data_in = d;
            @(posedge OPB_Clk);
            model_capture(d);
        end
        @(negedge OPB_Clk);
        user_valid = 0;
    endtask

    initial begin
        logic [31:0] r;
        int op;
        OPB_Rst = 1; OPB_ABus = 0; OPB_BE = 0; OPB_DBus = 0; OPB_RNW = 1;
        OPB_select = 0; OPB_seqAddr = 0; user_data_in = 0; user_valid = 0;
        model_reset();
        repeat (3) @(posedge OPB_Clk);
        #1;
        chk("rst_ack", 32'(Sl_xferAck), 0);
        chk("rst_dbus", Sl_DBus, 0);
        chk("tie_off", {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 0);
        @(negedge OPB_Clk);
        OPB_Rst = 0;

        rd_reg("r22_data", 0);
        rd_reg("r22_status", 2);

        wr_ctrl("r23_arm", 32'h1, 4'hF);
        capture_run(3, 32'hDEADBEEF, 0);
        rd_reg("r23_status", 2);
        rd_reg("r23_data", 0);
        rd_reg("r23_status2", 2);
        rd_reg("r23_ctrl", 1);

        wr_ctrl("r25_be", 32'h1, 4'b1110);
        rd_reg("r25_ctrl", 1);

        wr_ctrl("r26_cont", 32'h3, 4'hF);
        capture_run(1, 32'h11111111, 0);
        access("r26_rdcap", BASE, 1, 4'hF, 0, 1, 32'h22222222);
        rd_reg("r26_status", 2);
        rd_reg("r26_data", 0);

        wr_ctrl("r18_arm", 32'h1, 4'hF);
        access("r18_wrcap", BASE + 4, 0, 4'hF, 32'h2, 1, 32'h33333333);
        rd_reg("r18_status", 2);
        rd_reg("r18_data", 0);

        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: wr_ctrl("rnd_wr", $urandom, 4'($urandom));
                1: rd_reg("rnd_rd", ($urandom_range(0, 4) == 4) ? 63
                                    : $urandom_range(0, 3));
                2: capture_run($urandom_range(1, 3), 0, 1);
                3: access("rnd_cap", BASE + 4 * $urandom_range(0, 3),
                          1'($urandom), 4'($urandom), $urandom, 1, $urandom);
                default: rd_reg("rnd_status", 2);
            endcase
        end

        @(negedge OPB_Clk);
        OPB_ABus = BASE; OPB_RNW = 1; OPB_BE = 4'hF; OPB_select = 1;
        @(posedge OPB_Clk);
        #1 chk("r27_ack_before", 32'(Sl_xferAck), 1);
        OPB_Rst = 1;
        #1;
        chk("r27_ack_rst", 32'(Sl_xferAck), 0);
        chk("r27_dbus_rst", Sl_DBus, 0);
        OPB_select = 0;
        model_reset();
        @(negedge OPB_Clk);
        OPB_Rst = 0;
        @(posedge OPB_Clk);
        #1 chk("r27_no_ack", 32'(Sl_xferAck), 0);
        rd_reg("r27_status", 2);
        access("r27_oor", 32'h11000700, 1, 4'hF, 0, 0, 0);

        wr_ctrl("r24_cont", 32'h3, 4'hF);
        capture_run(65536, 0, 1);
        rd_reg("r24_status", 2);
        rd_reg("r24_data", 0);

        access("bnd_high", HIGH, 1, 4'hF, 0, 0, 0);
        access("bnd_above", HIGH + 1, 1, 4'hF, 0, 0, 0);
        access("bnd_below", BASE - 4, 1, 4'hF, 0, 0, 0);
        access("bnd_wr_oor", BASE - 4, 0, 4'hF, 32'h0, 0, 0);
        rd_reg("bnd_ctrl", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
OPB_REGISTER_SIMULINK2PPC_SNAP -- requirements
Module: opb_register_simulink2ppc_snap

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01100600, first byte address decoded.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h011006FF, last byte address decoded.
REQ-003 SHALL have parameters C_OPB_AWIDTH=32, C_OPB_DWIDTH=32, C_FAMILY="virtex6"; C_FAMILY is informational only.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: OPB_Clk in 1 (all logic), OPB_Rst in 1 (async, active-high).
REQ-005 SHALL have OPB slave inputs: OPB_ABus in [0:31] address; OPB_BE in [0:3] byte enables; OPB_DBus in [0:31] write data; OPB_RNW in 1 (1=read); OPB_select in 1; OPB_seqAddr in 1 (ignored).
REQ-006 SHALL have OPB slave outputs: Sl_DBus out [0:31] read data; Sl_xferAck out 1; Sl_errAck, Sl_retry, Sl_toutSup out 1 each.
REQ-007 SHALL have user ports: user_data_in in [31:0] fabric value, synchronous to OPB_Clk; user_valid in 1 (user_data_in qualifier).

Function
REQ-008 SHALL detect a hit when OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; the word offset is OPB_ABus[24:29] minus the base.
REQ-009 SHALL use FSM IDLE/ACK: IDLE->ACK on a hit; ACK->IDLE unconditionally; no back-to-back ACK, so each hit costs 2 cycles.
REQ-010 SHALL assert Sl_xferAck only in ACK, one cycle after the hit cycle.
REQ-011 SHALL drive Sl_DBus to all-zero outside ACK (wired-OR bus); read data is registered at the hit edge from the register state in the hit cycle.
REQ-012 SHALL tie Sl_errAck, Sl_retry and Sl_toutSup to 0.
REQ-013 SHALL decode the following register map.
  - Offset 0x0, DATA (RO): the 32-bit shadow register.
  - Offset 0x4, CTRL (RW): DBus[31]=arm (write-1 sets, reads current armed); DBus[30]=continuous.
  - Offset 0x8, STATUS (RO): DBus[0:15]=capture count; DBus[29]=continuous; DBus[30]=valid; DBus[31]=armed.
  - Other offsets: read 0; writes ignored; always acked.
REQ-014 SHALL write CTRL only when OPB_RNW=0 and OPB_BE[3]=1, with the update taking effect at the ACK edge; writing arm=0 disarms.
REQ-015 SHALL capture when armed=1 and user_valid=1 on a clock edge.
  - shadow <= user_data_in; valid <= 1; count <= count+1, modulo 2^16 (0xFFFF wraps to 0x0000).
  - armed <= 0 unless continuous=1.
REQ-016 SHALL clear valid at the ACK edge of a DATA read.
REQ-017 SHALL resolve a capture and a DATA-read ACK on the same edge as follows: the read returns the pre-capture shadow, valid ends at 1, and the new shadow is retained.
REQ-018 SHALL resolve a CTRL write and a capture on the same edge as follows: the capture uses the pre-write armed value, and the CTRL write determines the final armed/continuous values.
REQ-019 SHALL apply DATA reads as the only user-visible side effect; STATUS reads have none.

Reset
REQ-020 SHALL, while OPB_Rst=1, asynchronously force the following values.
  - FSM=IDLE; Sl_xferAck=0; Sl_DBus=0.
  - shadow=0; count=0; valid=0; armed=0; continuous=0.
REQ-021 SHALL abort an ACK in flight if reset is asserted mid-transaction; no ack is issued after reset release until a new hit.

Verification
REQ-022 SHALL pass: after reset, read 0x0 and 0x8 -> both return 0x00000000, each Sl_xferAck exactly 1 cycle, one cycle after select.
REQ-023 SHALL pass: write CTRL=0x00000001, drive user_data_in=0xDEADBEEF with user_valid=1 for 3 cycles -> DATA=0xDEADBEEF, STATUS=0x00010002 (count 1, valid, disarmed); then read DATA -> STATUS=0x00010000.
REQ-024 SHALL pass: write CTRL=0x00000003, give 0x10000 user_valid pulses -> count wraps to 0x0000, armed stays 1, shadow=last value.
REQ-025 SHALL pass: write CTRL=0x00000001 with OPB_BE=4'b1110 -> armed stays 0 and Sl_xferAck still pulses once.
REQ-026 SHALL pass: a capture on the same edge as a DATA-read ACK -> the read returns the old value and STATUS valid=1.
REQ-027 SHALL pass: OPB_Rst asserted during ACK -> Sl_xferAck drops immediately and Sl_DBus=0; access to 0x11000700 (out of range) -> no ack.
